// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: control FSM for the multi-cycle RV32I core.
// Sequences IF/ID/EX/MEM/WB over the shared ALU and the unified memory port,
// and drives every datapath mux/enable strobe. Halts on ECALL when x17 == 10.
//
// Build option: define MEM_WAIT_EN to let IF and MEM stall on mem_ready.
// Without it, mem_ready is ignored and each memory phase lasts one cycle.
//
// Memory handshake: the controller holds mem_read/mem_write/i_or_d constant
// while mem_ready is low; the access completes in the cycle where mem_ready
// is high, and only then do ir_write / pc_write / state advance.
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_cond,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_ctrl_op,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t cur_state;
  state_t nxt_state;
  logic   mem_rdy;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  // Memory is treated as always ready; mem_ready is intentionally unused.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_rdy = 1'b1;
`endif

  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_ecall;
  logic is_known;

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_ecall  = (opcode == OP_SYSTEM);
  assign is_known  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr;

  assign state = cur_state;

  // State register; reset returns to fetch immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_state <= S_IF;
    else          cur_state <= nxt_state;
  end

  // Next-state and strobe decode; everything is forced low while in reset.
  always_comb begin
    nxt_state   = cur_state;
    pc_write    = 1'b0;
    pc_source   = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_ctrl_op = 1'b0;
    halted      = 1'b0;
    case (cur_state)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_rdy;
        if (mem_rdy) nxt_state = S_ID;
      end
      S_ID: begin
        // ALUOut <- PC + imm for branch/jump targets.
        alu_src_b = 2'd2;
        if (is_ecall && halt_cond) begin
          nxt_state = S_HALT;
        end else if (is_ecall || !is_known) begin
          // Skip the instruction: PC <- PC + 4.
          alu_src_b = 2'd1;
          pc_write  = 1'b1;
          nxt_state = S_IF;
        end else begin
          nxt_state = S_EX;
        end
      end
      S_EX: begin
        if (is_r) begin
          alu_src_a = 1'b1; alu_ctrl_op = 1'b1; nxt_state = S_WB;
        end else if (is_i || is_jalr) begin
          alu_src_a = 1'b1; alu_src_b = 2'd2; alu_ctrl_op = 1'b1; nxt_state = S_WB;
        end else if (is_load || is_store) begin
          alu_src_a = 1'b1; alu_src_b = 2'd2; alu_ctrl_op = 1'b1; nxt_state = S_MEM;
        end else if (is_branch) begin
          alu_src_a = 1'b1; alu_ctrl_op = 1'b1;
          if (bcond) begin
            pc_write = 1'b1; pc_source = 1'b1; nxt_state = S_IF;
          end else begin
            nxt_state = S_WB;
          end
        end else if (is_jal) begin
          // rd <- PC + 4 while PC <- ALUOut (computed in ID).
          alu_src_b = 2'd1; reg_write = 1'b1; wb_sel = 2'd2;
          pc_write = 1'b1; pc_source = 1'b1; nxt_state = S_IF;
        end else begin
          nxt_state = S_IF;
        end
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (is_load) begin
          mem_read = 1'b1;
          if (mem_rdy) nxt_state = S_WB;
        end else begin
          mem_write = 1'b1;
          if (mem_rdy) begin
            alu_src_b = 2'd1; pc_write = 1'b1; nxt_state = S_IF;
          end
        end
      end
      S_WB: begin
        alu_src_b = 2'd1;
        pc_write  = 1'b1;
        nxt_state = S_IF;
        if (is_r || is_i) begin
          reg_write = 1'b1;
        end else if (is_load) begin
          reg_write = 1'b1; wb_sel = 2'd1;
        end else if (is_jalr) begin
          reg_write = 1'b1; wb_sel = 2'd2; pc_source = 1'b1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        nxt_state = S_IF;
      end
    endcase
    if (!reset_n) begin
      pc_write    = 1'b0;
      pc_source   = 1'b0;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      wb_sel      = 2'd0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'd0;
      alu_ctrl_op = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Control FSM for the multi-cycle RV32I CPU. Sequences instruction fetch, decode, execute, memory access and write-back over the shared ALU, unified memory port, IR/MDR/ALUOut registers and PC. Drives the 1-bit `alu_ctrl_op` consumed by the ALU control unit (0 = force add, 1 = decode from instruction) plus all datapath mux/enable strobes. Halts on ECALL when x17 == 10.

## Interface
- No parameters.
- `clk`  input  1  core clock, all state changes on rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `opcode`  input  7  IR[6:0], valid from ID onward
- `bcond`  input  1  ALU branch-compare result, valid in EX
- `halt_cond`  input  1  register-file x17 == 10
- `mem_ready`  input  1  memory access completes this cycle
- `state`  output  3  current state (IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5)
- `pc_write`  output  1  PC load enable
- `pc_source`  output  1  0 = ALU result, 1 = ALUOut register
- `i_or_d`  output  1  memory address: 0 = PC, 1 = ALUOut
- `mem_read` / `mem_write`  output  1 each  memory strobes
- `ir_write`  output  1  IR load enable (MDR loads every cycle)
- `reg_write`  output  1  register-file write enable
- `wb_sel`  output  2  rd data: 0 = ALUOut, 1 = MDR, 2 = ALU result
- `alu_src_a`  output  1  0 = PC, 1 = rs1
- `alu_src_b`  output  2  0 = rs2, 1 = constant 4, 2 = immediate
- `alu_ctrl_op`  output  1  0 = add, 1 = decode from instruction
- `halted`  output  1  high in HALT

## Operation
- Outputs combinational from state, opcode, bcond, mem_ready; every strobe not listed is 0.
- IF: i_or_d=0, mem_read=1, ir_write=mem_ready; → ID on mem_ready.
- ID: src_a=0, src_b=2, alu_ctrl_op=0 (ALUOut ← PC+imm).
  - ECALL: halt_cond → HALT; else src_b=1, pc_write=1, pc_source=0 → IF.
  - Unrecognised opcode: same as non-halting ECALL.
  - Otherwise → EX.
- EX:
  - R-type: src_a=1, src_b=0, alu_ctrl_op=1 → WB. I-arith: src_a=1, src_b=2, alu_ctrl_op=1 → WB.
  - LOAD/STORE: src_a=1, src_b=2, alu_ctrl_op=1 → MEM.
  - BRANCH: src_a=1, src_b=0, alu_ctrl_op=1; bcond → pc_write=1, pc_source=1, → IF; else → WB.
  - JAL: src_a=0, src_b=1, alu_ctrl_op=0, reg_write=1, wb_sel=2, pc_write=1, pc_source=1 → IF.
  - JALR: src_a=1, src_b=2, alu_ctrl_op=1 → WB.
- MEM: i_or_d=1; LOAD mem_read=1 → WB on mem_ready; STORE mem_write=1, and on mem_ready src_a=0, src_b=1, alu_ctrl_op=0, pc_write=1, pc_source=0 → IF.
- WB: all types src_a=0, src_b=1, alu_ctrl_op=0.
  - R/I: reg_write=1, wb_sel=0, pc_write=1, pc_source=0. LOAD: same with wb_sel=1.
  - Branch not taken: pc_write=1, pc_source=0.
  - JALR: reg_write=1, wb_sel=2, pc_write=1, pc_source=1. All → IF.
- HALT: all strobes 0, halted=1; exits only via reset.

## Timing
- reset_n low: state=IF immediately (async), every output forced 0; first fetch strobe on the first cycle after release.
- Cycles per instruction at zero wait: R/I 4, LOAD 5, STORE 4, branch taken 3 / not taken 4, JAL 3, JALR 4, ECALL 2.
- Memory wait: mem_read/mem_write/i_or_d held constant while mem_ready=0; no other strobe asserts during a wait.
- Reset asserted mid-instruction (including during wait or HALT): abort, no partial write completes on that edge.
- pc_write and reg_write are single-cycle pulses per instruction; never asserted twice for one instruction.

## Configuration
- `MEM_WAIT_EN` defined: IF and MEM stall on mem_ready as above.
- Undefined: mem_ready ignored and treated as 1; IF and MEM always last exactly one cycle.

## Test plan
- Reset: reset_n=0 mid-EX → state=0 and all outputs 0 within same cycle; release → mem_read=1, i_or_d=0.
- ADD (opcode 0110011) at zero wait → states 0,1,2,4,0; alu_ctrl_op=1 only in EX; reg_write and pc_write pulse once in WB.
- LW with `MEM_WAIT_EN`, mem_ready low 3 cycles in MEM → mem_read/i_or_d held 4 cycles, wb_sel=1 in WB, total 8 cycles.
- BEQ bcond=1 → IF after 3 cycles, pc_source=1; bcond=0 → WB with pc_source=0, 4 cycles.
- JAL → EX asserts reg_write, wb_sel=2, pc_write, pc_source=1 simultaneously; next state IF.
- ECALL halt_cond=1 → HALT, halted=1, no strobes for 20 cycles; halt_cond=0 → PC+4 write, back to IF in 2 cycles.
